// File: rtl/slowena_gen_pkg.sv
// Shared types and default sizing for the slowena enable-pulse generator.
// State encoding is one bit: the FSM only ever needs IDLE and RUN.
package slowena_gen_pkg;

  typedef enum logic {
    SG_IDLE = 1'b0,
    SG_RUN  = 1'b1
  } sg_state_e;

  localparam int SG_CNT_W       = 16;
  localparam int SG_BURST_W     = 8;
  localparam int SG_DEFAULT_DIV = 10;

endpackage

// File: rtl/slowena_prescaler.sv
// Divide-by-N prescaler with registered terminal count; ratio reloads only at period boundaries.
// Latency: tc high in the cycle the count equals max(ratio,1)-1; no backpressure, free-running while run.
module slowena_prescaler #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             run,
  input  logic             go,
  input  logic [CNT_W-1:0] div_shadow,
  output logic             tc
);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_act, div_n;
  logic [CNT_W-1:0] div_eff_n;

  // Next-cycle count and ratio are computed here so tc can be a plain flop.
  always_comb begin
    cnt_n = cnt;
    div_n = div_act;
    if (clr) begin
      cnt_n = '0;
      div_n = div_shadow;
    end else if (run) begin
      if (tc) begin
        cnt_n = '0;
        div_n = div_shadow;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  assign div_eff_n = (div_n == '0) ? CNT_W'(1) : div_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_act <= CNT_W'(DEFAULT_DIV);
      tc      <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_act <= div_n;
      tc      <= go && (cnt_n == div_eff_n - CNT_W'(1));
    end
  end

endmodule

// File: rtl/slowena_gen.sv
// Run/idle enable-strobe generator: continuous or fixed-burst slowena pulses at a loadable ratio.
// Latency: busy one cycle after start; all outputs registered; no backpressure. Option: SLOWENA_GEN_PULSE_CNT_EN.
module slowena_gen
  import slowena_gen_pkg::*;
#(
  parameter int CNT_W       = SG_CNT_W,
  parameter int DEFAULT_DIV = SG_DEFAULT_DIV,
  parameter int BURST_W     = SG_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_in,
  input  logic [BURST_W-1:0] burst_len,
  output logic               slowena,
  output logic               busy,
  output logic               done
`ifdef SLOWENA_GEN_PULSE_CNT_EN
  ,
  output logic [BURST_W-1:0] pulse_cnt
`endif
);

  sg_state_e          state, state_n;
  logic [CNT_W-1:0]   div_shadow;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] pcnt;
  logic               clr, done_n, tc, run, go, last_pulse;

  assign run        = (state == SG_RUN);
  assign go         = (state_n == SG_RUN);
  assign slowena    = tc;
  assign last_pulse = tc && (burst_q != '0) && (pcnt == burst_q - BURST_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SG_IDLE;
    else        state <= state_n;
  end

  // Stop has priority over both a fresh start and burst completion.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    done_n  = 1'b0;
    case (state)
      SG_IDLE: begin
        if (start && !stop) begin
          state_n = SG_RUN;
          clr     = 1'b1;
        end
      end
      SG_RUN: begin
        if (stop) begin
          state_n = SG_IDLE;
        end else if (last_pulse) begin
          state_n = SG_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = SG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      div_shadow <= CNT_W'(DEFAULT_DIV);
      burst_q    <= '0;
      pcnt       <= '0;
    end else begin
      busy <= go;
      done <= done_n;
      if (div_load) div_shadow <= div_in;
      if (clr) burst_q <= burst_len;
      // Continuous runs let the count wrap; finite runs saturate.
      if (clr) begin
        pcnt <= '0;
      end else if (run && tc && ((burst_q == '0) || (pcnt != '1))) begin
        pcnt <= pcnt + BURST_W'(1);
      end
    end
  end

  slowena_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .run        (run),
    .go         (go),
    .div_shadow (div_shadow),
    .tc         (tc)
  );

`ifdef SLOWENA_GEN_PULSE_CNT_EN
  assign pulse_cnt = pcnt;
`else
  // pcnt stays internal and only drives burst termination.
`endif

endmodule

// File: tb/tb_slowena_gen.sv
// Scoreboard bench for slowena_gen: expected pulse/done cycles queued at start, checked as they appear.
module tb_slowena_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic [7:0]  burst_len = '0;
  logic        slowena, busy, done;
`ifdef SLOWENA_GEN_PULSE_CNT_EN
  logic [7:0]  pulse_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int pq[$];
  int dq[$];
  logic [3:0] dcnt;
  logic       dc_clr = 1'b0;

  always #5 clk = ~clk;

  slowena_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .div_load  (div_load),
    .div_in    (div_in),
    .burst_len (burst_len),
    .slowena   (slowena),
    .busy      (busy),
    .done      (done)
`ifdef SLOWENA_GEN_PULSE_CNT_EN
    ,
    .pulse_cnt (pulse_cnt)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream decade counter fed by slowena.
  always @(posedge clk or negedge reset) begin
    if (!reset)         dcnt <= 4'd0;
    else if (dc_clr)    dcnt <= 4'd0;
    else if (slowena)   dcnt <= (dcnt == 4'd9) ? 4'd0 : dcnt + 4'd1;
  end

  always @(negedge clk) begin
    if (slowena) begin
      if (pq.size() == 0) chk("slowena_spurious", cyc, -1);
      else                chk("slowena_cyc", cyc, pq.pop_front());
      chk("slowena_busy", busy, 1);
    end
    if (done) begin
      if (dq.size() == 0) chk("done_spurious", cyc, -1);
      else                chk("done_cyc", cyc, dq.pop_front());
      chk("done_busy", busy, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_div(input int v);
    div_in   = 16'(v);
    div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask

  // Start a run now; cycle 1 is the cycle after the sampling edge.
  task automatic run(input int nb, input int dv, input int np);
    burst_len = 8'(nb);
    start     = 1'b1;
    t0        = cyc;
    for (int k = 1; k <= np; k++) pq.push_back(t0 + k * dv);
    if (nb != 0) dq.push_back(t0 + nb * dv + 1);
    tick(1);
    start = 1'b0;
    chk("busy_on", busy, 1);
  endtask

  task automatic drain(input string tag);
    chk(tag, pq.size() + dq.size(), 0);
    pq.delete();
    dq.delete();
  endtask

  initial begin
    #1;
    chk("rst_slowena", slowena, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Mid-run async reset, then default ratio 10 on the next run.
    load_div(3);
    run(0, 3, 4);
    tick(12);
    reset = 1'b0;
    #1;
    chk("arst_slowena", slowena, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    drain("sb_pre_reset");
    tick(1);
    reset = 1'b1;
    tick(1);
    run(2, 10, 2);
    tick(22);
    drain("sb_default_div");

    // Burst of 3 at ratio 4.
    dc_clr = 1'b1;
    load_div(4);
    dc_clr = 1'b0;
    run(3, 4, 3);
    tick(15);
    chk("dcnt_burst3", dcnt, 3);
    drain("sb_burst3");

    // Continuous at ratio 1 with stop at cycle 25.
    dc_clr = 1'b1;
    load_div(1);
    dc_clr = 1'b0;
    run(0, 1, 25);
    tick(9);
    chk("dcnt_c10", dcnt, 9);
    tick(1);
    chk("dcnt_wrap", dcnt, 0);
    tick(14);
    chk("busy_c25", busy, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_slowena", slowena, 0);
    tick(3);
    drain("sb_cont");

    // Ratio 0 acts as 1; start+stop together in IDLE stays idle.
    load_div(0);
    run(3, 1, 3);
    tick(5);
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 0);
    tick(3);
    chk("ss_busy_later", busy, 0);
    drain("sb_div0");

    // Ratio change mid-period takes effect at the next boundary.
    load_div(5);
    run(0, 5, 2);
    pq.push_back(t0 + 12);
    pq.push_back(t0 + 14);
    tick(6);
    div_in   = 16'd2;
    div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
    tick(6);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("reload_stop_busy", busy, 0);
    tick(3);
    drain("sb_reload");

    // Start ignored during RUN; restart in the done cycle.
    load_div(3);
    run(2, 3, 2);
    tick(2);
    start     = 1'b1;
    burst_len = 8'd7;
    tick(1);
    start = 1'b0;
    tick(3);
    run(1, 3, 1);
    tick(6);
    drain("sb_restart");

`ifdef SLOWENA_GEN_PULSE_CNT_EN
    load_div(2);
    run(5, 2, 5);
    tick(2);
    chk("pcnt_1", pulse_cnt, 1);
    tick(8);
    chk("pcnt_5", pulse_cnt, 5);
    tick(4);
    chk("pcnt_hold", pulse_cnt, 5);
    run(1, 2, 1);
    chk("pcnt_clr", pulse_cnt, 0);
    tick(4);
    drain("sb_pcnt");
`endif

    chk("sb_final", pq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slowena_gen.md
# slowena_gen

Programmable enable-pulse generator that produces the single-cycle `slowena` strobe consumed directly by the slow-down decade counter. It divides `clk` by a runtime-loadable ratio and emits one `slowena` pulse per period. It runs either continuously or for a fixed burst of pulses. Start and stop are driven by a small run/idle state machine.

## Interface
Parameters:
- `CNT_W`, 16, width of the divide ratio and prescaler counter.
- `DEFAULT_DIV`, 10, divide ratio loaded at reset.
- `BURST_W`, 8, width of burst length and pulse counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin pulsing.
- `stop`  in  1  level-sampled request to abort pulsing.
- `div_load`  in  1  load `div_in` into the shadow divide register.
- `div_in`  in  CNT_W  new divide ratio; 0 treated as 1.
- `burst_len`  in  BURST_W  pulses per run, captured at start; 0 = continuous.
- `slowena`  out  1  one-cycle enable strobe to the downstream counter.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a finite burst completes.

## Operation
- States: IDLE and RUN. Reset enters IDLE.
- Reset values:
  - Outputs: `slowena`=0, `busy`=0, `done`=0.
  - Internal: prescaler count=0, pulse count=0, shadow and active divide=DEFAULT_DIV.
- `div_load`:
  - Writes the shadow register in any state.
  - The active ratio copies the shadow when entering RUN and at each period boundary (the cycle `slowena` is high).
  - A ratio never changes mid-period.
- Effective ratio `div_act` = max(active ratio, 1).
- IDLE→RUN: `start`=1 and `stop`=0. On entry: capture `burst_len`, clear the prescaler and pulse count.
- In RUN:
  - The prescaler increments each cycle and wraps from `div_act`-1 to 0.
  - `slowena`=1 exactly in cycles where the prescaler equals `div_act`-1.
  - Pulse count increments on each `slowena` and saturates at its max.
- RUN→IDLE:
  - On `stop`=1, in the next cycle, with no `done`. A `slowena` due in the stop cycle is still emitted.
  - Or after pulse number `burst_len` when `burst_len`≠0, with `done`=1 in the first IDLE cycle.
- `start` while in RUN is ignored (no restart). `start` and `stop` high together: stop wins.
- Continuous mode (`burst_len`=0): the pulse count wraps and never terminates the run.
- Asynchronous reset mid-run: immediate return to IDLE, all outputs 0, shadow ratio back to DEFAULT_DIV.

## Timing
- All outputs are registered and glitch-free. Control inputs are sampled on the rising edge.
- `start` sampled at edge E0: `busy`=1 from cycle 1.
- The first `slowena` is in cycle `div_act`, then every `div_act` cycles.
- `div_act`=1 gives `slowena` high every RUN cycle.
- Finite burst of N pulses: last pulse in cycle N·`div_act`; `busy` low and `done` high in cycle N·`div_act`+1.
- Stop latency: one cycle from the sampled `stop` to `busy`=0.
- Re-start is allowed in the same cycle as `done`: `start` sampled at the edge that produces `done` re-enters RUN in the following cycle.

## Configuration
- `SLOWENA_GEN_PULSE_CNT_EN`:
  - Defined: adds output `pulse_cnt` [BURST_W-1:0], the registered pulse count of the current run. It resets to 0, clears on RUN entry, and holds its value in IDLE.
  - Undefined: port absent. The internal pulse count exists only as needed for burst termination; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - State enum (`SG_IDLE`, `SG_RUN`).
  - Default widths `SG_CNT_W`=16 and `SG_BURST_W`=8.
  - `SG_DEFAULT_DIV`=10.
- One sub-module, `slowena_prescaler`: counter with terminal-count output and period-boundary ratio reload. The FSM, burst logic and shadow register stay in the top.

## Test plan
- Reset asserted mid-run with `div_in`=3 loaded → outputs 0 immediately. After release, the first run uses ratio 10: `slowena` in cycles 10, 20 after start.
- `div_in`=4, `burst_len`=3, pulse `start` → `slowena` in cycles 4, 8, 12; `done` in cycle 13. Downstream counter from 0 reads q=0011.
- `burst_len`=0, `div_in`=1 → `slowena` every cycle. Downstream counter wraps 9→0 after 10 cycles. `stop` at cycle 25 → `busy` low in cycle 26.
- `div_in`=0 → behaves as ratio 1. `start` and `stop` high together in IDLE → stays IDLE, no `slowena`.
- During RUN at ratio 5, load ratio 2 at cycle 7 → pulses at 5 and 10 (period unchanged), then 12, 14.
- With `SLOWENA_GEN_PULSE_CNT_EN`, `burst_len`=5 → `pulse_cnt` steps 1..5, holds 5 in IDLE, clears to 0 on the next start.
